// File: rtl/keypad_event_ctrl_pkg.sv
// Shared encodings for the keypad event controller: key codes, FSM states,
// per-frame scan results and the key-to-mask helper.
package keypad_event_ctrl_pkg;

    localparam logic [3:0] NO_KEY         = 4'd9;
    localparam int         NUM_KEYS       = 9;
    localparam int         SCAN_LEN_DEF   = 4;
    localparam int         DEB_FRAMES_DEF = 2;
    localparam int         REL_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAND      = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_RELEASING = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FR_EMPTY    = 2'd0,
        FR_KEY      = 2'd1,
        FR_CONFLICT = 2'd2
    } frame_res_e;

    // Codes 9..15 map to an empty mask, so they never count as a key.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] code);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            mask[i] = (code == 4'(i));
        end
        return mask;
    endfunction

endpackage

// File: rtl/keypad_event_ctrl_sampler.sv
// Groups scanner ticks into frames and classifies each frame as empty,
// a single key, or a conflict of two or more distinct keys.
module keypad_event_ctrl_sampler
    import keypad_event_ctrl_pkg::*;
#(
    parameter int SCAN_LEN = SCAN_LEN_DEF
) (
    input  logic       clk_100Hz,
    input  logic       reset,
    input  logic [3:0] raw_key,
    output logic       frame_done,
    output frame_res_e frame_res,
    output logic [3:0] frame_key
);

    localparam logic [2:0] LAST_TICK = 3'(SCAN_LEN - 1);

    logic [2:0]          cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] seen_q, seen_d;
    logic [NUM_KEYS-1:0] seen_all;
    logic [3:0]          hits;

    // The frame-end tick's own sample is folded in before classification.
    always_comb begin
        seen_all   = seen_q | key_onehot(raw_key);
        frame_done = (cnt_q == LAST_TICK);
        cnt_d      = frame_done ? 3'd0 : cnt_q + 3'd1;
        seen_d     = frame_done ? '0 : seen_all;
        hits       = 4'd0;
        frame_key  = NO_KEY;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (seen_all[i]) begin
                hits      = hits + 4'd1;
                frame_key = 4'(i);
            end
        end
        if (hits == 4'd0) begin
            frame_res = FR_EMPTY;
        end else if (hits == 4'd1) begin
            frame_res = FR_KEY;
        end else begin
            frame_res = FR_CONFLICT;
        end
    end

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            cnt_q  <= 3'd0;
            seen_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Debounce / n-key-lockout FSM with a valid/ack event register for keypad presses.
// state        | meaning
// ST_IDLE      | no key accepted, waiting for a single-key frame
// ST_CAND      | candidate key seen in cnt consecutive frames
// ST_PRESSED   | press accepted and emitted; other keys locked out
// ST_RELEASING | cnt consecutive empty frames seen since press
module keypad_event_ctrl
    import keypad_event_ctrl_pkg::*;
#(
    parameter int SCAN_LEN   = SCAN_LEN_DEF,
    parameter int DEB_FRAMES = DEB_FRAMES_DEF,
    parameter int REL_FRAMES = REL_FRAMES_DEF
) (
    input  logic       clk_100Hz,
    input  logic       reset,
    input  logic [3:0] raw_key,
    input  logic       key_ack,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       key_overrun
);

    localparam logic [3:0] DEB_N = 4'(DEB_FRAMES);
    localparam logic [3:0] REL_N = 4'(REL_FRAMES);

    logic       frame_done;
    frame_res_e frame_res;
    logic [3:0] frame_key;

    state_e     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       emit;
    logic       valid_q, valid_d;
    logic [3:0] code_q, code_d;
    logic       held_q, held_d;
    logic       overrun_q, overrun_d;

    keypad_event_ctrl_sampler #(
        .SCAN_LEN(SCAN_LEN)
    ) u_sampler (
        .clk_100Hz (clk_100Hz),
        .reset     (reset),
        .raw_key   (raw_key),
        .frame_done(frame_done),
        .frame_res (frame_res),
        .frame_key (frame_key)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        cnt_inc = cnt_q + 4'd1;
        if (frame_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_res == FR_KEY) begin
                        state_d = ST_CAND;
                        cand_d  = frame_key;
                        cnt_d   = 4'd1;
                    end
                end
                ST_CAND: begin
                    if (frame_res == FR_KEY && frame_key == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_N) begin
                            state_d = ST_PRESSED;
                            emit    = 1'b1;
                        end
                    end else if (frame_res == FR_KEY) begin
                        cand_d = frame_key;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_res == FR_EMPTY) begin
                        state_d = ST_RELEASING;
                        cnt_d   = 4'd1;
                    end
                end
                ST_RELEASING: begin
                    if (frame_res == FR_EMPTY) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == REL_N) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // A same-cycle ack frees the slot, so a simultaneous emit loads rather than overruns.
    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        overrun_d = 1'b0;
        held_d    = (state_d == ST_PRESSED) || (state_d == ST_RELEASING);
        if (valid_q && key_ack) begin
            valid_d = 1'b0;
        end
        if (emit) begin
            if (valid_q && !key_ack) begin
                overrun_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = cand_q;
            end
        end
    end

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cand_q    <= NO_KEY;
            cnt_q     <= 4'd0;
            valid_q   <= 1'b0;
            code_q    <= NO_KEY;
            held_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            held_q    <= held_d;
            overrun_q <= overrun_d;
        end
    end

    assign key_valid   = valid_q;
    assign key_code    = code_q;
    assign key_held    = held_q;
    assign key_overrun = overrun_q;

endmodule
